inst_fetch: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I core.
- Owns the PC and issues requests to instruction memory over a level req/ack handshake.
- Presents instruction/instruction_address to ID.
- Consumes the EXE redirect (if_jump_flag/if_jump_address); absorbs ID stalls with a 1-entry skid buffer.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_skid_buf.sv | 46 ++++
 rtl/inst_fetch.sv | 147 ++++++++++++++
 tb/tb_inst_fetch.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared core definitions: reset/bubble defaults, fetch FSM states and the
// control-flow opcodes that EXE and the ALU controller decode.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_1000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_IDLE   = 2'd1,
    S_SQUASH = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instruction, address} holding buffer that catches a fetch
// response arriving while ID is stalled.
module fetch_skid_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_drain,
  input  logic        i_flush,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_addr,
  output logic [31:0] o_inst,
  output logic [31:0] o_addr,
  output logic        o_full
);

  logic        r_full;
  logic [31:0] r_inst;
  logic [31:0] r_addr;

  // Load wins over drain so a drain and a refill in one cycle keeps the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
    end else if (i_flush) begin
      r_full <= 1'b0;
    end else if (i_load) begin
      r_full <= 1'b1;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_inst <= i_inst;
      r_addr <= i_addr;
    end
  end

  assign o_inst = r_inst;
  assign o_addr = r_addr;
  assign o_full = r_full;

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction-fetch stage: owns the PC, runs the imem req/ack
// handshake, honours EXE redirects and absorbs ID stalls via a skid entry.
module inst_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump_flag,
  input  logic [31:0] jump_address,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] instruction_address,
  output logic        instruction_valid
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_addr;
  logic         r_req;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_addr;
  logic         r_valid;

  logic         w_ack;
  logic         w_take;
  logic         w_hold;
  logic         w_drain;
  logic         w_skid_load;
  logic         w_skid_full;
  logic         w_skid_full_nxt;
  logic [31:0]  w_skid_inst;
  logic [31:0]  w_skid_addr;
  logic [31:0]  w_target;
  logic [31:0]  w_pc_inc;

  // Responses in SQUASH belong to the abandoned path and are never delivered.
  assign w_ack           = r_req & imem_ack;
  assign w_take          = w_ack & (r_state != S_SQUASH);
  assign w_hold          = stall & r_valid;
  assign w_drain         = ~w_hold & w_skid_full;
  assign w_skid_load     = w_take & (w_hold | w_skid_full);
  assign w_skid_full_nxt = ~jump_flag & (w_skid_load | (w_skid_full & ~w_drain));
  assign w_target        = word_align(jump_address);
  assign w_pc_inc        = r_pc + 32'd4;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_skid_load),
    .i_drain (w_drain),
    .i_flush (jump_flag),
    .i_inst  (imem_rdata),
    .i_addr  (r_addr),
    .o_inst  (w_skid_inst),
    .o_addr  (w_skid_addr),
    .o_full  (w_skid_full)
  );

  // A redirect with a request still in flight must keep that address on the
  // bus until the memory acks it, so the target waits in r_pc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
    end else if (jump_flag) begin
      r_pc  <= w_target;
      r_req <= 1'b1;
      if (r_req && !imem_ack) begin
        r_state <= S_SQUASH;
      end else begin
        r_state <= S_REQ;
        r_addr  <= w_target;
      end
    end else begin
      case (r_state)
        S_REQ: begin
          r_req <= 1'b1;
          if (w_ack) begin
            r_pc   <= w_pc_inc;
            r_addr <= w_pc_inc;
            if (w_skid_full_nxt) begin
              r_state <= S_IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        S_IDLE: begin
          if (!w_skid_full) begin
            r_state <= S_REQ;
            r_req   <= 1'b1;
          end
        end
        S_SQUASH: begin
          if (w_ack) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
        end
        default: begin
          r_state <= S_REQ;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  // The skid entry is older than any response in flight, so it goes out first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst      <= NOP_INST;
      r_inst_addr <= 32'd0;
      r_valid     <= 1'b0;
    end else if (jump_flag) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end else if (w_hold) begin
      r_valid <= 1'b1;
    end else if (w_skid_full) begin
      r_inst      <= w_skid_inst;
      r_inst_addr <= w_skid_addr;
      r_valid     <= 1'b1;
    end else if (w_take) begin
      r_inst      <= imem_rdata;
      r_inst_addr <= r_addr;
      r_valid     <= 1'b1;
    end else if (!stall) begin
      r_inst  <= NOP_INST;
      r_valid <= 1'b0;
    end
  end

  assign imem_req            = r_req;
  assign imem_addr           = r_addr;
  assign instruction         = r_inst;
  assign instruction_address = r_inst_addr;
  assign instruction_valid   = r_valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a latency-programmable memory that
// returns the fetch address as the instruction word.
module tb_inst_fetch;

  logic        clk;
  logic        rst_n;
  logic        jump_flag;
  logic [31:0] jump_address;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic [31:0] instruction_address;
  logic        instruction_valid;

  logic        ack_en;
  int          lat;
  int          cnt;
  int          n_chk;
  int          n_pass;

  localparam logic [31:0] NOP = 32'h0000_0013;

  inst_fetch dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .jump_flag           (jump_flag),
    .jump_address        (jump_address),
    .stall               (stall),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_ack            (imem_ack),
    .imem_rdata          (imem_rdata),
    .instruction         (instruction),
    .instruction_address (instruction_address),
    .instruction_valid   (instruction_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_ack   = imem_req & ack_en & (cnt >= lat);
  assign imem_rdata = imem_addr;

  always @(posedge clk) begin
    if (!imem_req || imem_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset(input int latency);
    rst_n        = 1'b0;
    jump_flag    = 1'b0;
    jump_address = 32'd0;
    stall        = 1'b0;
    ack_en       = 1'b1;
    lat          = latency;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!instruction_valid && n < 20);
    if (!instruction_valid) chk({tag, "_timeout"}, {31'd0, instruction_valid}, 32'd1);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cnt    = 0;

    // Reset values and zero-wait streaming
    do_reset(0);
    rst_n = 1'b0;
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h1000);
    chk("rst_inst", instruction, NOP);
    chk("rst_iaddr", instruction_address, 32'd0);
    chk("rst_valid", {31'd0, instruction_valid}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("zw_req1", {31'd0, imem_req}, 32'd1);
    chk("zw_addr1", imem_addr, 32'h1000);
    chk("zw_valid1", {31'd0, instruction_valid}, 32'd0);
    tick();
    chk("zw_valid2", {31'd0, instruction_valid}, 32'd1);
    chk("zw_iaddr2", instruction_address, 32'h1000);
    chk("zw_inst2", instruction, 32'h1000);
    chk("zw_addr2", imem_addr, 32'h1004);
    tick();
    chk("zw_iaddr3", instruction_address, 32'h1004);
    chk("zw_addr3", imem_addr, 32'h1008);

    // Three-cycle ack latency
    do_reset(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("lat_req%0d", i), {31'd0, imem_req}, 32'd1);
      chk($sformatf("lat_addr%0d", i), imem_addr, 32'h1000);
      chk($sformatf("lat_valid%0d", i), {31'd0, instruction_valid}, 32'd0);
    end
    tick();
    chk("lat_valid", {31'd0, instruction_valid}, 32'd1);
    chk("lat_iaddr", instruction_address, 32'h1000);
    chk("lat_next", imem_addr, 32'h1004);

    // Stall for four cycles while 1004 is on the output
    do_reset(0);
    tick();
    tick();
    tick();
    chk("st_pre", instruction_address, 32'h1004);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("st_hold%0d", i), instruction_address, 32'h1004);
      chk($sformatf("st_req%0d", i), {31'd0, imem_req}, 32'd0);
    end
    chk("st_hvalid", {31'd0, instruction_valid}, 32'd1);
    stall = 1'b0;
    tick();
    chk("st_skid", instruction_address, 32'h1008);
    chk("st_skid_inst", instruction, 32'h1008);
    wait_valid("st_w1");
    chk("st_next", instruction_address, 32'h100C);
    tick();
    chk("st_next2", instruction_address, 32'h1010);
    chk("st_next2_v", {31'd0, instruction_valid}, 32'd1);

    // Redirect while 1010 is outstanding, then back-to-back redirects in SQUASH
    do_reset(0);
    for (int i = 0; i < 5; i++) tick();
    chk("sq_pre", imem_addr, 32'h1010);
    ack_en       = 1'b0;
    jump_flag    = 1'b1;
    jump_address = 32'h0000_2002;
    tick();
    jump_flag = 1'b0;
    chk("sq_hold1", imem_addr, 32'h1010);
    chk("sq_req1", {31'd0, imem_req}, 32'd1);
    chk("sq_valid1", {31'd0, instruction_valid}, 32'd0);
    chk("sq_inst1", instruction, NOP);
    tick();
    chk("sq_hold2", imem_addr, 32'h1010);
    chk("sq_valid2", {31'd0, instruction_valid}, 32'd0);
    ack_en = 1'b1;
    tick();
    chk("sq_tgt", imem_addr, 32'h2000);
    chk("sq_valid3", {31'd0, instruction_valid}, 32'd0);
    tick();
    chk("sq_deliv", instruction_address, 32'h2000);
    chk("sq_deliv_v", {31'd0, instruction_valid}, 32'd1);
    chk("sq_pend", imem_addr, 32'h2004);
    ack_en       = 1'b0;
    jump_flag    = 1'b1;
    jump_address = 32'h0000_2800;
    tick();
    chk("bb_hold1", imem_addr, 32'h2004);
    jump_address = 32'h0000_2C00;
    tick();
    jump_flag = 1'b0;
    ack_en    = 1'b1;
    chk("bb_hold2", imem_addr, 32'h2004);
    tick();
    chk("bb_tgt", imem_addr, 32'h2C00);
    wait_valid("bb_w");
    chk("bb_deliv", instruction_address, 32'h2C00);

    // Redirect while stalled with the skid full
    do_reset(0);
    tick();
    tick();
    tick();
    stall = 1'b1;
    tick();
    chk("js_req", {31'd0, imem_req}, 32'd0);
    jump_flag    = 1'b1;
    jump_address = 32'h0000_3000;
    tick();
    chk("js_valid", {31'd0, instruction_valid}, 32'd0);
    chk("js_addr", imem_addr, 32'h3000);
    jump_flag = 1'b0;
    stall     = 1'b0;
    wait_valid("js_w");
    chk("js_deliv", instruction_address, 32'h3000);

    // Reset asserted with a request in flight
    do_reset(2);
    for (int i = 0; i < 5; i++) tick();
    chk("mr_pre", {31'd0, imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_req", {31'd0, imem_req}, 32'd0);
    chk("mr_addr", imem_addr, 32'h1000);
    chk("mr_valid", {31'd0, instruction_valid}, 32'd0);
    chk("mr_inst", instruction, NOP);
    chk("mr_iaddr", instruction_address, 32'd0);
    lat = 0;
    tick();
    rst_n = 1'b1;
    wait_valid("mr_w");
    chk("mr_deliv", instruction_address, 32'h1000);

    // Jump coincident with ack, unaligned target, PC wrap
    do_reset(0);
    tick();
    tick();
    jump_flag    = 1'b1;
    jump_address = 32'hFFFF_FFF9;
    tick();
    jump_flag = 1'b0;
    chk("wr_addr", imem_addr, 32'hFFFF_FFF8);
    chk("wr_valid", {31'd0, instruction_valid}, 32'd0);
    tick();
    chk("wr_d0", instruction_address, 32'hFFFF_FFF8);
    tick();
    chk("wr_d1", instruction_address, 32'hFFFF_FFFC);
    tick();
    chk("wr_d2", instruction_address, 32'h0000_0000);
    chk("wr_d2_v", {31'd0, instruction_valid}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
